// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI4-Lite slave in front of a single-ported, word-addressed SRAM array.
// Handles one transaction at a time and applies byte strobes on writes.
// A read wins a same-cycle tie with a write in IDLE. Addresses outside the
// window complete normally but return SLVERR and never touch the array.
// The array has no reset, so its contents survive ARESETn.

module axi_sram_slave #(
  parameter int unsigned               AXI_ADDR_BITS = 32,
  parameter int unsigned               AXI_DATA_BITS = 32,
  parameter logic [AXI_ADDR_BITS-1:0]  BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned               DEPTH_WORDS   = 16384
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  // read address channel
  input  logic [AXI_ADDR_BITS-1:0]     ARADDR_S,
  input  logic                         ARVALID_S,
  output logic                         ARREADY_S,
  // read data channel
  output logic [AXI_DATA_BITS-1:0]     RDATA_S,
  output logic [1:0]                   RRESP_S,
  output logic                         RVALID_S,
  input  logic                         RREADY_S,
  // write address channel
  input  logic [AXI_ADDR_BITS-1:0]     AWADDR_S,
  input  logic                         AWVALID_S,
  output logic                         AWREADY_S,
  // write data channel
  input  logic [AXI_DATA_BITS-1:0]     WDATA_S,
  input  logic [AXI_DATA_BITS/8-1:0]   WSTRB_S,
  input  logic                         WVALID_S,
  output logic                         WREADY_S,
  // write response channel
  output logic [1:0]                   BRESP_S,
  output logic                         BVALID_S,
  input  logic                         BREADY_S
);

  localparam int unsigned BYTES    = AXI_DATA_BITS / 8;
  localparam int unsigned OFF_BITS = $clog2(BYTES);
  localparam int unsigned IDX_BITS = $clog2(DEPTH_WORDS);
  localparam logic [AXI_ADDR_BITS-1:0] WINDOW_BYTES = AXI_ADDR_BITS'(DEPTH_WORDS * BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WR_COLLECT = 2'd1,
    ST_RD_RESP    = 2'd2,
    ST_WR_RESP    = 2'd3
  } state_t;

  // Merge the strobed bytes of new_word into old_word.
  function automatic logic [AXI_DATA_BITS-1:0] merge_bytes(
    input logic [AXI_DATA_BITS-1:0] old_word,
    input logic [AXI_DATA_BITS-1:0] new_word,
    input logic [BYTES-1:0]         strb
  );
    logic [AXI_DATA_BITS-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(BYTES); b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // storage
  logic [AXI_DATA_BITS-1:0] mem_q [DEPTH_WORDS];

  // control state
  state_t                   state_q, state_d;
  logic                     ready_en_q;
  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic [AXI_ADDR_BITS-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]         wstrb_q, wstrb_d;
  logic [AXI_DATA_BITS-1:0] rdata_q;
  logic [1:0]               rresp_q, rresp_d;
  logic [1:0]               bresp_q, bresp_d;

  // handshakes and decode
  logic                     arready_s, awready_s, wready_s;
  logic                     ar_hs_s, aw_hs_s, w_hs_s;
  logic                     aw_avail_s, w_avail_s, wr_commit_s;
  logic [AXI_ADDR_BITS-1:0] rd_off_s, wr_addr_s, wr_off_s;
  logic [AXI_DATA_BITS-1:0] wr_data_s;
  logic [BYTES-1:0]         wr_strb_s;
  logic                     rd_in_range_s, wr_in_range_s;
  logic [IDX_BITS-1:0]      rd_idx_s, wr_idx_s;

  // Address decode: offsets wrap below BASE_ADDR, so one unsigned compare covers both ends.
  always_comb begin
    rd_off_s      = ARADDR_S - BASE_ADDR;
    rd_in_range_s = (rd_off_s < WINDOW_BYTES);
    rd_idx_s      = rd_off_s[OFF_BITS +: IDX_BITS];
    wr_addr_s     = aw_held_q ? awaddr_q : AWADDR_S;
    wr_data_s     = w_held_q ? wdata_q : WDATA_S;
    wr_strb_s     = w_held_q ? wstrb_q : WSTRB_S;
    wr_off_s      = wr_addr_s - BASE_ADDR;
    wr_in_range_s = (wr_off_s < WINDOW_BYTES);
    wr_idx_s      = wr_off_s[OFF_BITS +: IDX_BITS];
  end

  // Channel readies: read has priority in IDLE, write halves fill independently.
  always_comb begin
    arready_s = 1'b0;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    if (!ready_en_q) begin
      arready_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      arready_s = 1'b1;
      awready_s = !ARVALID_S && !aw_held_q;
      wready_s  = !ARVALID_S && !w_held_q;
    end else if (state_q == ST_WR_COLLECT) begin
      awready_s = !aw_held_q;
      wready_s  = !w_held_q;
    end else begin
      arready_s = 1'b0;
    end
  end

  assign ar_hs_s    = ARVALID_S && arready_s;
  assign aw_hs_s    = AWVALID_S && awready_s;
  assign w_hs_s     = WVALID_S && wready_s;
  assign aw_avail_s = aw_held_q || aw_hs_s;
  assign w_avail_s  = w_held_q || w_hs_s;

  // Next-state logic: one transaction at a time, commit when both write halves are present.
  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rresp_d     = rresp_q;
    bresp_d     = bresp_q;
    wr_commit_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_WR_COLLECT: begin
        if (ar_hs_s) begin
          rresp_d = rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
          state_d = ST_RD_RESP;
        end else if (aw_avail_s && w_avail_s) begin
          wr_commit_s = 1'b1;
          bresp_d     = wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
          aw_held_d   = 1'b0;
          w_held_d    = 1'b0;
          state_d     = ST_WR_RESP;
        end else begin
          if (aw_hs_s) begin
            aw_held_d = 1'b1;
            awaddr_d  = AWADDR_S;
          end else begin
            aw_held_d = aw_held_q;
          end
          if (w_hs_s) begin
            w_held_d = 1'b1;
            wdata_d  = WDATA_S;
            wstrb_d  = WSTRB_S;
          end else begin
            w_held_d = w_held_q;
          end
          if (aw_hs_s || w_hs_s) begin
            state_d = ST_WR_COLLECT;
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_RD_RESP: begin
        if (RREADY_S) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_RESP;
        end
      end
      ST_WR_RESP: begin
        if (BREADY_S) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
  end

  // Control registers; reset discards any half-collected write.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bresp_q    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
    end
  end

  // Registered read data: captured from the array on the AR handshake, zero when out of range.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_q <= '0;
    end else if (ar_hs_s) begin
      if (rd_in_range_s) begin
        rdata_q <= mem_q[rd_idx_s];
      end else begin
        rdata_q <= '0;
      end
    end else begin
      rdata_q <= rdata_q;
    end
  end

  // Array write port: byte-strobed update on commit, never for out-of-range addresses.
  always_ff @(posedge ACLK) begin
    if (wr_commit_s && wr_in_range_s) begin
      mem_q[wr_idx_s] <= merge_bytes(mem_q[wr_idx_s], wr_data_s, wr_strb_s);
    end
  end

  assign ARREADY_S = arready_s;
  assign AWREADY_S = awready_s;
  assign WREADY_S  = wready_s;
  assign RVALID_S  = (state_q == ST_RD_RESP);
  assign BVALID_S  = (state_q == ST_WR_RESP);
  assign RDATA_S   = rdata_q;
  assign RRESP_S   = rresp_q;
  assign BRESP_S   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: inputs driven on the falling edge,
// outputs sampled 1 ns later, expected values written out by hand.

module tb_axi_sram_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] ARADDR_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic [31:0] AWADDR_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;

  int errors = 0;
  int checks = 0;

  axi_sram_slave dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARADDR_S  (ARADDR_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .AWADDR_S  (AWADDR_S),
    .AWVALID_S (AWVALID_S),
    .AWREADY_S (AWREADY_S),
    .WDATA_S   (WDATA_S),
    .WSTRB_S   (WSTRB_S),
    .WVALID_S  (WVALID_S),
    .WREADY_S  (WREADY_S),
    .BRESP_S   (BRESP_S),
    .BVALID_S  (BVALID_S),
    .BREADY_S  (BREADY_S)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    ARADDR_S  = a;
    ARVALID_S = 1'b1;
    n = 0;
    #1;
    while (!ARREADY_S && n < 20) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    if (!ARREADY_S) check("rd_ar_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    #1;
    check("rd_r_latency", 32'(RVALID_S), 32'd1);
    data = RDATA_S;
    resp = RRESP_S;
    n = 0;
    while (RVALID_S && n < 20) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    check("rd_arready_back", 32'(ARREADY_S), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    logic aw_ok, w_ok;
    @(negedge ACLK);
    AWADDR_S  = a;
    AWVALID_S = 1'b1;
    WDATA_S   = d;
    WSTRB_S   = s;
    WVALID_S  = 1'b1;
    n = 0;
    while ((AWVALID_S || WVALID_S) && n < 20) begin
      #1;
      aw_ok = AWVALID_S && AWREADY_S;
      w_ok  = WVALID_S && WREADY_S;
      @(negedge ACLK);
      if (aw_ok) AWVALID_S = 1'b0;
      if (w_ok)  WVALID_S  = 1'b0;
      n++;
    end
    if (AWVALID_S || WVALID_S) begin
      check("wr_hs_timeout", 32'd0, 32'd1);
      AWVALID_S = 1'b0;
      WVALID_S  = 1'b0;
    end
    #1;
    check("wr_b_latency", 32'(BVALID_S), 32'd1);
    resp = BRESP_S;
    n = 0;
    while (BVALID_S && n < 20) begin
      @(negedge ACLK);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  bs;

    ARESETn   = 1'b0;
    ARADDR_S  = 32'd0;
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b1;
    AWADDR_S  = 32'd0;
    AWVALID_S = 1'b0;
    WDATA_S   = 32'd0;
    WSTRB_S   = 4'd0;
    WVALID_S  = 1'b0;
    BREADY_S  = 1'b1;

    // reset state
    repeat (3) @(negedge ACLK);
    #1;
    check("rst_readies", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd0);
    check("rst_valids", 32'({RVALID_S, BVALID_S}), 32'd0);
    check("rst_rdata", RDATA_S, 32'd0);
    check("rst_resps", 32'({RRESP_S, BRESP_S}), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("post_rst_first_cycle_readies", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd0);
    @(negedge ACLK);
    #1;
    check("post_rst_readies_on", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd7);

    // preload and read back mem[0]
    do_write(32'h0000_0000, 32'hDEAD_BEEF, 4'hF, bs);
    check("preload0_bresp", 32'(bs), 32'd0);
    do_write(32'h0000_0010, 32'hAAAA_AAAA, 4'hF, bs);
    check("preload4_bresp", 32'(bs), 32'd0);
    do_read(32'h0000_0000, rd, rs);
    check("rd0_data", rd, 32'hDEAD_BEEF);
    check("rd0_resp", 32'(rs), 32'd0);

    // byte-strobed write
    do_write(32'h0000_0010, 32'h1234_5678, 4'b0101, bs);
    check("strb_bresp", 32'(bs), 32'd0);
    do_read(32'h0000_0010, rd, rs);
    check("strb_data", rd, 32'hAA34_AA78);

    // zero strobe: nothing changes, OKAY
    do_write(32'h0000_0012, 32'hFFFF_FFFF, 4'b0000, bs);
    check("strb0_bresp", 32'(bs), 32'd0);
    do_read(32'h0000_0013, rd, rs);
    check("strb0_data_low_bits_ignored", rd, 32'hAA34_AA78);

    // W three cycles before AW
    @(negedge ACLK);
    WDATA_S  = 32'h0000_0055;
    WSTRB_S  = 4'hF;
    WVALID_S = 1'b1;
    #1;
    check("wfirst_wready", 32'(WREADY_S), 32'd1);
    @(negedge ACLK);
    WVALID_S = 1'b0;
    #1;
    check("wfirst_collect_arready", 32'(ARREADY_S), 32'd0);
    check("wfirst_collect_wready", 32'(WREADY_S), 32'd0);
    check("wfirst_collect_awready", 32'(AWREADY_S), 32'd1);
    repeat (2) @(negedge ACLK);
    AWADDR_S  = 32'h0000_0020;
    AWVALID_S = 1'b1;
    #1;
    check("wfirst_awready", 32'(AWREADY_S), 32'd1);
    @(negedge ACLK);
    AWVALID_S = 1'b0;
    #1;
    check("wfirst_bvalid", 32'(BVALID_S), 32'd1);
    check("wfirst_bresp", 32'(BRESP_S), 32'd0);
    check("wfirst_wr_resp_readies", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd0);
    @(negedge ACLK);
    #1;
    check("wfirst_bvalid_done", 32'(BVALID_S), 32'd0);
    do_read(32'h0000_0020, rd, rs);
    check("wfirst_data", rd, 32'h0000_0055);

    // same-cycle read/write tie: read first
    @(negedge ACLK);
    ARADDR_S  = 32'h0000_0000;
    ARVALID_S = 1'b1;
    AWADDR_S  = 32'h0000_0024;
    AWVALID_S = 1'b1;
    WDATA_S   = 32'hCAFE_F00D;
    WSTRB_S   = 4'hF;
    WVALID_S  = 1'b1;
    #1;
    check("tie_ready_vec", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd4);
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    #1;
    check("tie_rvalid", 32'(RVALID_S), 32'd1);
    check("tie_no_bvalid", 32'(BVALID_S), 32'd0);
    check("tie_rdata", RDATA_S, 32'hDEAD_BEEF);
    @(negedge ACLK);
    #1;
    check("tie_write_ready_after_r", 32'({AWREADY_S, WREADY_S}), 32'd3);
    @(negedge ACLK);
    AWVALID_S = 1'b0;
    WVALID_S  = 1'b0;
    #1;
    check("tie_bvalid", 32'(BVALID_S), 32'd1);
    check("tie_no_rvalid", 32'(RVALID_S), 32'd0);
    @(negedge ACLK);
    do_read(32'h0000_0024, rd, rs);
    check("tie_write_data", rd, 32'hCAFE_F00D);

    // out-of-range read and write at BASE + DEPTH*4
    do_read(32'h0001_0000, rd, rs);
    check("oor_rresp", 32'(rs), 32'd2);
    check("oor_rdata", rd, 32'd0);
    do_write(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, bs);
    check("oor_bresp", 32'(bs), 32'd2);
    do_read(32'h0000_0000, rd, rs);
    check("oor_array_unchanged", rd, 32'hDEAD_BEEF);
    check("after_oor_rresp_okay", 32'(rs), 32'd0);

    // read stall, then reset mid-response
    RREADY_S = 1'b0;
    @(negedge ACLK);
    ARADDR_S  = 32'h0000_0010;
    ARVALID_S = 1'b1;
    #1;
    check("stall_arready", 32'(ARREADY_S), 32'd1);
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_rvalid", 32'(RVALID_S), 32'd1);
      check("stall_rdata", RDATA_S, 32'hAA34_AA78);
      @(negedge ACLK);
    end
    #2;
    ARESETn = 1'b0;
    #1;
    check("async_rst_rvalid", 32'(RVALID_S), 32'd0);
    check("async_rst_readies", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd0);
    check("async_rst_rdata", RDATA_S, 32'd0);
    @(negedge ACLK);
    ARESETn  = 1'b1;
    RREADY_S = 1'b1;
    #1;
    check("post_rst2_first_cycle_readies", 32'({ARREADY_S, AWREADY_S, WREADY_S}), 32'd0);
    @(negedge ACLK);
    #1;
    check("post_rst2_arready", 32'(ARREADY_S), 32'd1);
    do_read(32'h0000_0010, rd, rs);
    check("array_survives_reset", rd, 32'hAA34_AA78);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
